seq_generator: RTL
==================

SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving pattern length in bits (min 2).
REQ-002 The block SHALL have parameter REP_W, default 4, giving width of the repeat count.
REQ-003 The block SHALL have parameter GAP_W, default 4, giving width of the inter-pattern gap count.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, request to begin a transmission; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1, synchronous cancel of any transmission in progress.
REQ-008 The block SHALL have port pattern, input, PAT_W, the bits to serialize, MSB transmitted first.
REQ-009 The block SHALL have port reps, input, REP_W, the number of pattern repetitions.
REQ-010 The block SHALL have port gap, input, GAP_W, the number of idle (x=0) cycles between repetitions.
REQ-011 The block SHALL have port x, output, 1, registered serial bit stream; it is the stimulus input of a sequence detector.
REQ-012 The block SHALL have port valid, output, 1, registered; high while x carries a pattern bit.
REQ-013 The block SHALL have port frame, output, 1, registered; high only on the first (MSB) bit of each repetition.
REQ-014 The block SHALL have port busy, output, 1, registered; high in SEND and GAP.
REQ-015 The block SHALL have port done, output, 1, registered one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL latch pattern, reps and gap into internal registers; later changes on those inputs SHALL NOT affect the transmission in progress.
REQ-018 The first pattern bit SHALL appear on x, with valid=1 and frame=1, in the cycle immediately after the edge that samples start=1.
REQ-019 In SEND, the block SHALL shift out one bit per cycle, MSB first, holding valid=1 for exactly PAT_W cycles per repetition.
REQ-020 After the last bit of a repetition with repetitions remaining and latched gap=0, the next repetition's MSB SHALL follow on the very next cycle with no bubble.
REQ-021 After the last bit of a repetition with repetitions remaining and latched gap>0, the block SHALL enter GAP for exactly gap cycles with x=0, valid=0 and busy=1, then return to SEND.
REQ-022 After the last bit of the final repetition, the block SHALL enter DONE for one cycle: done=1, busy=0, x=0, valid=0. It SHALL then return to IDLE.
REQ-023 No gap SHALL be inserted after the final repetition.
REQ-024 If start=1 with latched reps=0, the block SHALL send no bits, SHALL go directly to DONE and pulse done one cycle after the start edge, and busy SHALL remain 0.
REQ-025 The repetition counter SHALL decrement once per completed repetition and SHALL NOT wrap; at maximum reps (2^REP_W-1) all repetitions SHALL be sent.
REQ-026 The block SHALL ignore start while busy=1 or while in DONE.
REQ-027 When abort=1 in any state, the next edge SHALL take the block to IDLE with x=0, valid=0, frame=0 and busy=0, and done SHALL NOT pulse.
REQ-028 If start and abort are both 1 in IDLE, abort SHALL win and no transmission SHALL start.
REQ-029 In IDLE, x, valid, frame, busy and done SHALL all be 0.

Reset
REQ-030 When rst=0 at a rising edge, the state SHALL become IDLE and x, valid, frame, busy and done SHALL be 0; internal shift, rep and gap registers SHALL be cleared.
REQ-031 Reset SHALL take priority over abort and start.
REQ-032 Reset asserted mid-transmission SHALL truncate it immediately, with no done pulse.
REQ-033 The first start SHALL be honoured on the first edge with rst=1.

Verification
REQ-034 Scenario 1: pattern=0110, reps=1, gap=0, start pulse -> x=0,1,1,0 with valid=1 for 4 cycles, frame only on the first bit, done=1 on cycle 5, busy high for cycles 1-4.
REQ-035 Scenario 2: pattern=1011, reps=2, gap=0 -> x=10111011 back-to-back with valid continuous for 8 cycles, frame on cycles 1 and 5, done on cycle 9.
REQ-036 Scenario 3: pattern=0110, reps=3, gap=2 -> x stream 0110,00,0110,00,0110 with valid low only during the two-cycle gaps, frame pulsing 3 times, done on cycle 17.
REQ-037 Scenario 4: start re-pulsed and pattern changed mid-transmission -> output stream unchanged from Scenario 1, with only one done pulse.
REQ-038 Scenario 5: abort on the 3rd bit -> IDLE outputs (all 0) on the next cycle, no done pulse, and a fresh start afterwards transmits normally.
REQ-039 Scenario 6: rst=0 on the 2nd bit -> all outputs 0 on the next cycle; reps=0 start -> done pulse one cycle later with valid never asserted.

Source files
------------

// File: rtl/seq_generator.sv
// Pattern serializer that drives a sequence detector under test.
// Sends a latched pattern MSB-first, reps times, with optional idle gaps.
module seq_generator #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] MSB = BW'(PAT_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             x_q, x_d;
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Output registers hold the values for the state being entered,
    // so x/valid/frame line up with the state one cycle after the edge.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        bit_d   = bit_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        frame_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_d = pattern;
                        rep_d = reps;
                        gap_d = gap;
                        if (reps == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SEND;
                            bit_d   = MSB;
                            x_d     = pattern[PAT_W-1];
                            valid_d = 1'b1;
                            frame_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                SEND: begin
                    busy_d = 1'b1;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        x_d     = pat_q[bit_q-1'b1];
                        valid_d = 1'b1;
                    end else if (rep_q > REP_W'(1)) begin
                        rep_d = rep_q - 1'b1;
                        if (gap_q == '0) begin
                            bit_d   = MSB;
                            x_d     = pat_q[PAT_W-1];
                            valid_d = 1'b1;
                            frame_d = 1'b1;
                        end else begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                        end
                    end else begin
                        rep_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                GAP: begin
                    busy_d = 1'b1;
                    if (gcnt_q == GAP_W'(1)) begin
                        state_d = SEND;
                        bit_d   = MSB;
                        x_d     = pat_q[PAT_W-1];
                        valid_d = 1'b1;
                        frame_d = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            bit_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            bit_q   <= bit_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
